// File: rtl/seg7_mux2.sv
// Two-digit multiplexed seven-segment driver with per-frame digit snapshot,
// optional leading-zero blanking and a decimal-point flash after each carry.
//
// state  | meaning
// S_IDLE | after reset, nothing displayed until the first tick
// S_ONES | ones digit enabled, dp may be lit
// S_TENS | tens digit enabled (or blanked), dp dark
module seg7_mux2 #(
    parameter int REFRESH_DIV    = 12000,
    parameter int FLASH_LEN      = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_1,
    input  logic [3:0] digit_10,
    input  logic       carry,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic       frame
);

    localparam int            CW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST       = CW'(REFRESH_DIV - 1);
    localparam logic [7:0]    FLASH_INIT = 8'(FLASH_LEN);

    typedef enum logic [1:0] {S_IDLE, S_ONES, S_TENS} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count;
    logic          tick;
    logic          frame_start;
    logic [3:0]    shadow_10;
    logic [7:0]    flash, flash_nxt;
    logic          pending, pending_nxt;

    // Output registers hold active-high values; polarity is applied at the pins.
    logic [6:0]    seg_r, seg_nxt;
    logic [1:0]    an_r, an_nxt;
    logic          dp_r, dp_nxt;
    logic          frame_r;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    assign tick        = (count == LAST);
    assign frame_start = tick && (state != S_ONES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                S_IDLE:  state_nxt = S_ONES;
                S_ONES:  state_nxt = S_TENS;
                S_TENS:  state_nxt = S_ONES;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // A carry on the frame-start cycle itself is folded straight into the flash.
    always_comb begin
        flash_nxt   = flash;
        pending_nxt = pending | carry;
        if (frame_start) begin
            pending_nxt = 1'b0;
            if (pending || carry) begin
                flash_nxt = FLASH_INIT;
            end else if (flash != 8'd0) begin
                flash_nxt = flash - 8'd1;
            end
        end
    end

    // The ones pattern is decoded straight from the input on the frame-start
    // edge, so the seg register itself is the ones-digit snapshot.
    always_comb begin
        seg_nxt = seg_r;
        an_nxt  = an_r;
        dp_nxt  = dp_r;
        if (tick) begin
            case (state_nxt)
                S_ONES: begin
                    seg_nxt = seg_decode(digit_1);
                    an_nxt  = 2'b01;
                    dp_nxt  = (flash_nxt != 8'd0);
                end
                S_TENS: begin
                    dp_nxt = 1'b0;
                    if (blank_lz && (shadow_10 == 4'd0)) begin
                        seg_nxt = 7'h00;
                        an_nxt  = 2'b00;
                    end else begin
                        seg_nxt = seg_decode(shadow_10);
                        an_nxt  = 2'b10;
                    end
                end
                default: begin
                    seg_nxt = 7'h00;
                    an_nxt  = 2'b00;
                    dp_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            shadow_10 <= 4'd0;
            flash     <= 8'd0;
            pending   <= 1'b0;
            seg_r     <= 7'h00;
            an_r      <= 2'b00;
            dp_r      <= 1'b0;
            frame_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            flash   <= flash_nxt;
            pending <= pending_nxt;
            seg_r   <= seg_nxt;
            an_r    <= an_nxt;
            dp_r    <= dp_nxt;
            frame_r <= frame_start;
            if (frame_start) begin
                shadow_10 <= digit_10;
            end
        end
    end

    assign seg   = seg_r ^ {7{SEG_ACTIVE_LOW}};
    assign an    = an_r ^ {2{SEG_ACTIVE_LOW}};
    assign dp    = dp_r ^ SEG_ACTIVE_LOW;
    assign frame = frame_r;

endmodule

// File: tb/tb_seg7_mux2.sv
// Bench for seg7_mux2: an edge-counting reference model derives the expected
// display from slot/frame arithmetic; scenario tasks compare the DUT against it.
module tb_seg7_mux2;

    localparam int REFRESH_DIV = 4;
    localparam int FLASH_LEN   = 2;
    localparam logic [6:0] PAT [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                          7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                                          7'h40, 7'h40, 7'h40, 7'h40};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit_1 = 4'd0;
    logic [3:0] digit_10 = 4'd0;
    logic       carry = 1'b0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;
    logic       frame;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_mux2 #(
        .REFRESH_DIV(REFRESH_DIV),
        .FLASH_LEN(FLASH_LEN),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .digit_1(digit_1),
        .digit_10(digit_10),
        .carry(carry),
        .blank_lz(blank_lz),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame(frame)
    );

    always #5 clk = ~clk;

    // Reference model: edge e (counted from reset release) starts slot e/4-1
    // when e is a multiple of 4; even slots are ONES, frame index = slot/2.
    // A carry seen at or before a frame-start edge lights dp for that frame and
    // the next FLASH_LEN-1 frames.
    int         m_edges;
    bit         m_carry_seen;
    int         m_last;
    logic [3:0] m_sh10;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_frame;

    function automatic bit next_is_ones();
        int e = m_edges + 1;
        return (e >= 4) && (e % 8 == 4);
    endfunction

    function automatic bit next_is_tens();
        int e = m_edges + 1;
        return (e >= 8) && (e % 8 == 0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_edges      <= 0;
            m_carry_seen <= 1'b0;
            m_last       <= -1000;
            m_sh10       <= 4'd0;
            exp_an       <= 2'b11;
            exp_seg      <= 7'h7F;
            exp_dp       <= 1'b1;
            exp_frame    <= 1'b0;
        end else begin
            m_edges   <= m_edges + 1;
            exp_frame <= 1'b0;
            if (next_is_ones()) begin
                m_sh10       <= digit_10;
                m_carry_seen <= 1'b0;
                if (carry || m_carry_seen) m_last <= ((m_edges + 1) / 4 - 1) / 2;
                exp_an    <= 2'b10;
                exp_seg   <= ~PAT[digit_1];
                exp_dp    <= ~((carry || m_carry_seen) ||
                               ((((m_edges + 1) / 4 - 1) / 2 - m_last) < FLASH_LEN));
                exp_frame <= 1'b1;
            end else begin
                m_carry_seen <= m_carry_seen | carry;
                if (next_is_tens()) begin
                    exp_dp <= 1'b1;
                    if (blank_lz && m_sh10 == 4'd0) begin
                        exp_an  <= 2'b11;
                        exp_seg <= 7'h7F;
                    end else begin
                        exp_an  <= 2'b01;
                        exp_seg <= ~PAT[m_sh10];
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [10:0] dark = {2'b11, 7'h7F, 1'b1, 1'b0};
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({an, seg, dp, frame} !== dark) begin
                n_bad++;
                $display("FAIL reset_hold got %h exp %h", {an, seg, dp, frame}, dark);
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (i <= 3 && {an, seg, dp, frame} !== dark) begin
                n_bad++;
                $display("FAIL reset_release edge%0d got %h exp %h", i, {an, seg, dp, frame}, dark);
            end else if (i == 4 && {an, frame} !== 3'b101) begin
                n_bad++;
                $display("FAIL first_ones an/frame got %b exp 101", {an, frame});
            end else if (i == 5 && frame !== 1'b0) begin
                n_bad++;
                $display("FAIL frame_width got %b exp 0", frame);
            end
        end
    endtask

    task automatic test_steady();
        int frames = 0;
        digit_10 = 4'd1; digit_1 = 4'd2; blank_lz = 1'b0;
        repeat (16) @(negedge clk);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
                n_bad++;
                $display("FAIL steady got %h exp %h", {an, seg, dp, frame},
                         {exp_an, exp_seg, exp_dp, exp_frame});
            end
            if (frame) frames++;
            if (an == 2'b10 && seg !== 7'h24) begin
                n_bad++;
                $display("FAIL steady_ones seg got %h exp 24", seg);
            end
            if (an == 2'b01 && seg !== 7'h79) begin
                n_bad++;
                $display("FAIL steady_tens seg got %h exp 79", seg);
            end
        end
        n_cmp++;
        if (frames != 3) begin
            n_bad++;
            $display("FAIL steady_frames got %0d exp 3", frames);
        end
    endtask

    task automatic test_coherency();
        digit_10 = 4'd0; digit_1 = 4'd9; blank_lz = 1'b0;
        repeat (16) @(negedge clk);
        for (int g = 0; g < 16 && !next_is_tens(); g++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        digit_10 = 4'd1; digit_1 = 4'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (seg !== ((c < 6) ? 7'h40 : 7'h79) ||
                {an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
                n_bad++;
                $display("FAIL coherency c%0d got %h exp %h", c, {an, seg, dp, frame},
                         {exp_an, exp_seg, exp_dp, exp_frame});
            end
        end
    endtask

    task automatic test_blanking();
        int blanked = 0;
        for (int k = 0; k < 3; k++) begin
            digit_10 = 4'd0;
            digit_1  = (k == 2) ? 4'd0 : 4'd5;
            blank_lz = (k != 1);
            for (int c = 0; c < 24; c++) begin
                @(negedge clk);
                n_cmp++;
                if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
                    n_bad++;
                    $display("FAIL blanking k%0d got %h exp %h", k, {an, seg, dp, frame},
                             {exp_an, exp_seg, exp_dp, exp_frame});
                end
                if (c >= 16 && an == 2'b11) blanked++;
            end
        end
        n_cmp++;
        if (blanked != 8) begin
            n_bad++;
            $display("FAIL blanking_slots got %0d exp 8", blanked);
        end
    endtask

    task automatic test_carry();
        int lit = 0;
        digit_10 = 4'd3; digit_1 = 4'd7; blank_lz = 1'b0;
        for (int g = 0; g < 16 && !next_is_ones(); g++) @(negedge clk);
        for (int c = 0; c < 64; c++) begin
            carry = (c == 3 || c == 19);
            @(negedge clk);
            n_cmp++;
            if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
                n_bad++;
                $display("FAIL carry_mid c%0d got %h exp %h", c, {an, seg, dp, frame},
                         {exp_an, exp_seg, exp_dp, exp_frame});
            end
            if (frame && !dp) lit++;
        end
        carry = 1'b0;
        n_cmp++;
        if (lit != 4) begin
            n_bad++;
            $display("FAIL carry_restart lit_frames got %0d exp 4", lit);
        end
        lit = 0;
        for (int g = 0; g < 16 && !next_is_ones(); g++) @(negedge clk);
        for (int c = 0; c < 32; c++) begin
            carry = (c == 0);
            @(negedge clk);
            n_cmp++;
            if ((c == 0 && {dp, frame} !== 2'b01) ||
                {an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
                n_bad++;
                $display("FAIL carry_on_tick c%0d got %h exp %h", c, {an, seg, dp, frame},
                         {exp_an, exp_seg, exp_dp, exp_frame});
            end
            if (frame && !dp) lit++;
        end
        carry = 1'b0;
        n_cmp++;
        if (lit != 2) begin
            n_bad++;
            $display("FAIL carry_on_tick lit_frames got %0d exp 2", lit);
        end
    endtask

    task automatic test_invalid_reset();
        int lit = 0;
        digit_1 = 4'hA; digit_10 = 4'($urandom_range(15, 10)); blank_lz = 1'b1;
        for (int c = 0; c < 24; c++) begin
            carry = (c == 14);
            @(negedge clk);
            n_cmp++;
            if ((c >= 8 && frame && seg !== 7'h3F) ||
                {an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
                n_bad++;
                $display("FAIL invalid_code c%0d got %h exp %h", c, {an, seg, dp, frame},
                         {exp_an, exp_seg, exp_dp, exp_frame});
            end
        end
        carry = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({an, seg, dp, frame} !== {2'b11, 7'h7F, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset got %h exp %h", {an, seg, dp, frame},
                     {2'b11, 7'h7F, 1'b1, 1'b0});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
                n_bad++;
                $display("FAIL reset_mid_flash c%0d got %h exp %h", c, {an, seg, dp, frame},
                         {exp_an, exp_seg, exp_dp, exp_frame});
            end
            if (frame && !dp) lit++;
        end
        n_cmp++;
        if (lit != 0) begin
            n_bad++;
            $display("FAIL reset_clears_flash lit_frames got %0d exp 0", lit);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(7, 0) == 0) begin
                digit_1  = 4'($urandom_range(15, 0));
                digit_10 = ($urandom_range(3, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 0));
                blank_lz = 1'($urandom_range(1, 0));
            end
            carry = ($urandom_range(29, 0) == 0);
            @(negedge clk);
            n_cmp++;
            if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
                n_bad++;
                $display("FAIL random c%0d got %h exp %h", c, {an, seg, dp, frame},
                         {exp_an, exp_seg, exp_dp, exp_frame});
            end
        end
        carry = 1'b0;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_coherency();
        test_blanking();
        test_carry();
        test_invalid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
